// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequencing controller for an external combinational ALU.
// Accepts one MIPS-encoded instruction at a time, checks that it is legal,
// presents it to the ALU for a single cycle, captures the result, writes the
// two-entry register file and returns the result over a valid/ready handshake.
// The host can preload regA/regB while the controller is idle.
// Optional feature macro: ALU_SEQ_OVF_TRAP_EN (overflow trap, suppresses
// writeback of overflowing results and raises a sticky trap flag).
module alu_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        ld_en,
  input  logic        ld_sel,
  input  logic [31:0] ld_data,
  output logic [31:0] alu_instruction,
  output logic [31:0] alu_regA,
  output logic [31:0] alu_regB,
  input  logic [31:0] alu_result,
  input  logic [2:0]  alu_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_flags,
  output logic        out_err,
  output logic [31:0] reg_a,
  output logic [31:0] reg_b,
  output logic        trap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] instr_q;
  logic [31:0] reg_a_q;
  logic [31:0] reg_b_q;
  logic [31:0] out_result_q;
  logic [2:0]  out_flags_q;
  logic        out_err_q;

  logic        in_legal;
  logic        accept;
  logic        wb_en_d;
  logic        wb_sel_d;
  logic        ovf_block;

  // R-type function codes the ALU implements.
  function automatic logic funct_ok(input logic [5:0] f);
    logic ok;
    ok = 1'b0;
    case (f)
      6'b100000, 6'b100001, 6'b100010, 6'b100011,
      6'b100100, 6'b100111, 6'b100101, 6'b100110,
      6'b101010, 6'b101011, 6'b000000, 6'b000100,
      6'b000010, 6'b000110, 6'b000011, 6'b000111: ok = 1'b1;
      default:                                    ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Non-R-type opcodes the ALU implements.
  function automatic logic op_ok(input logic [5:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      6'b001000, 6'b001001, 6'b001100, 6'b001101,
      6'b001110, 6'b000100, 6'b000101, 6'b001010,
      6'b001011, 6'b100011, 6'b101011:            ok = 1'b1;
      default:                                    ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Legality of the offered instruction: known opcode/funct and every
  // register field addressing one of the two implemented registers.
  always_comb begin
    in_legal = 1'b0;
    if (in_instr[25:22] == 4'd0 && in_instr[20:17] == 4'd0) begin
      if (in_instr[31:26] == 6'b000000)
        in_legal = funct_ok(in_instr[5:0]) && (in_instr[15:12] == 4'd0);
      else
        in_legal = op_ok(in_instr[31:26]);
    end
  end

  // Writeback target decode for the instruction currently executing.
  always_comb begin
    wb_en_d  = 1'b0;
    wb_sel_d = 1'b0;
    case (instr_q[31:26])
      6'b000000: begin
        wb_en_d  = 1'b1;
        wb_sel_d = instr_q[11];
      end
      6'b001000, 6'b001001, 6'b001100, 6'b001101,
      6'b001110, 6'b001010, 6'b001011: begin
        wb_en_d  = 1'b1;
        wb_sel_d = instr_q[16];
      end
      default: begin
        wb_en_d  = 1'b0;
        wb_sel_d = 1'b0;
      end
    endcase
  end

  // Host loads take priority over instruction acceptance while idle.
  assign in_ready = (state_q == IDLE) && !ld_en;
  assign accept   = in_valid && in_ready;

  // ALU operands are only driven during the single execute cycle.
  always_comb begin
    alu_instruction = '0;
    alu_regA        = '0;
    alu_regB        = '0;
    if (state_q == EXEC) begin
      alu_instruction = instr_q;
      alu_regA        = reg_a_q;
      alu_regB        = reg_b_q;
    end
  end

`ifdef ALU_SEQ_OVF_TRAP_EN
  logic trap_q;

  assign ovf_block = alu_flags[0];

  // Sticky trap: set by an overflowing execution, cleared by the next accept.
  always_ff @(posedge clk) begin
    if (rst)
      trap_q <= 1'b0;
    else if (accept)
      trap_q <= 1'b0;
    else if (state_q == EXEC && ovf_block)
      trap_q <= 1'b1;
  end

  assign trap = trap_q;
`else
  assign ovf_block = 1'b0;
  assign trap      = 1'b0;
`endif

  // Control FSM with register file and registered response payload.
  // The ALU result is captured and written back on the same edge, so a
  // destination that is also a source is read before it is overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      instr_q      <= '0;
      reg_a_q      <= '0;
      reg_b_q      <= '0;
      out_result_q <= '0;
      out_flags_q  <= '0;
      out_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ld_en) begin
            if (ld_sel)
              reg_b_q <= ld_data;
            else
              reg_a_q <= ld_data;
          end else if (in_valid) begin
            instr_q <= in_instr;
            if (in_legal) begin
              state_q <= EXEC;
            end else begin
              state_q      <= RESP;
              out_result_q <= '0;
              out_flags_q  <= '0;
              out_err_q    <= 1'b1;
            end
          end
        end
        EXEC: begin
          out_result_q <= alu_result;
          out_flags_q  <= alu_flags;
          out_err_q    <= 1'b0;
          if (wb_en_d && !ovf_block) begin
            if (wb_sel_d)
              reg_b_q <= alu_result;
            else
              reg_a_q <= alu_result;
          end
          state_q <= RESP;
        end
        RESP: begin
          if (out_ready)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid  = (state_q == RESP);
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;
  assign out_err    = out_err_q;
  assign reg_a      = reg_a_q;
  assign reg_b      = reg_b_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: behavioural ALU stub, reference model
// of the register file, scoreboard queue and an independent response monitor.
module tb_alu_seq_ctrl;

`ifdef ALU_SEQ_OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [5:0] FUNCTS [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h27,
                                         6'h25, 6'h26, 6'h2a, 6'h2b, 6'h00, 6'h04,
                                         6'h02, 6'h06, 6'h03, 6'h07};
  localparam logic [5:0] OPS [11] = '{6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h04,
                                      6'h05, 6'h0a, 6'h0b, 6'h23, 6'h2b};
  localparam logic [5:0] WB_OPS [7] = '{6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h0b};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        ld_en;
  logic        ld_sel;
  logic [31:0] ld_data;
  logic [31:0] alu_instruction, alu_regA, alu_regB;
  logic [31:0] alu_result;
  logic [2:0]  alu_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;
  logic        out_err;
  logic [31:0] reg_a, reg_b;
  logic        trap;

  alu_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .ld_en(ld_en), .ld_sel(ld_sel), .ld_data(ld_data),
    .alu_instruction(alu_instruction), .alu_regA(alu_regA), .alu_regB(alu_regB),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_err(out_err),
    .reg_a(reg_a), .reg_b(reg_b), .trap(trap)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flags;
    logic        err;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        trap;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_a, m_b;
  logic        m_trap;
  int          rmode = 0;  // 0 random out_ready, 1 held low, 2 held high

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural ALU: operand select by register field, MIPS semantics,
  // flags {zero, negative, signed overflow}.
  function automatic logic [34:0] alu_ref(input logic [31:0] ins, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] s, t, simm, zimm, r;
    logic        ov;
    s    = ins[21] ? b : a;
    t    = ins[16] ? b : a;
    simm = {{16{ins[15]}}, ins[15:0]};
    zimm = {16'h0, ins[15:0]};
    r    = '0;
    ov   = 1'b0;
    if (ins[31:26] == 6'h00) begin
      case (ins[5:0])
        6'h20: begin r = s + t; ov = (s[31] == t[31]) && (r[31] != s[31]); end
        6'h21: r = s + t;
        6'h22: begin r = s - t; ov = (s[31] != t[31]) && (r[31] != s[31]); end
        6'h23: r = s - t;
        6'h24: r = s & t;
        6'h27: r = ~(s | t);
        6'h25: r = s | t;
        6'h26: r = s ^ t;
        6'h2a: r = {31'h0, $signed(s) < $signed(t)};
        6'h2b: r = {31'h0, s < t};
        6'h00: r = t << ins[10:6];
        6'h04: r = t << s[4:0];
        6'h02: r = t >> ins[10:6];
        6'h06: r = t >> s[4:0];
        6'h03: r = $signed(t) >>> ins[10:6];
        6'h07: r = $signed(t) >>> s[4:0];
        default: r = '0;
      endcase
    end else begin
      case (ins[31:26])
        6'h08: begin r = s + simm; ov = (s[31] == simm[31]) && (r[31] != s[31]); end
        6'h09: r = s + simm;
        6'h0c: r = s & zimm;
        6'h0d: r = s | zimm;
        6'h0e: r = s ^ zimm;
        6'h0a: r = {31'h0, $signed(s) < $signed(simm)};
        6'h0b: r = {31'h0, s < simm};
        6'h04, 6'h05: r = s - t;
        6'h23, 6'h2b: r = s + simm;
        default: r = '0;
      endcase
    end
    return {r == 32'h0, r[31], ov, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_ref(alu_instruction, alu_regA, alu_regB);

  function automatic bit legal_ref(input logic [31:0] ins);
    bit ok = 1'b0;
    if (ins[31:26] == 6'h00) begin
      foreach (FUNCTS[i]) if (ins[5:0] == FUNCTS[i]) ok = 1'b1;
      if (ins[15:11] > 5'd1) ok = 1'b0;
    end else begin
      foreach (OPS[i]) if (ins[31:26] == OPS[i]) ok = 1'b1;
    end
    if (ins[25:21] > 5'd1 || ins[20:16] > 5'd1) ok = 1'b0;
    return ok;
  endfunction

  // -1: no write, 0: regA, 1: regB
  function automatic int wb_target(input logic [31:0] ins);
    int tgt = -1;
    if (ins[31:26] == 6'h00) tgt = int'(ins[11]);
    foreach (WB_OPS[i]) if (ins[31:26] == WB_OPS[i]) tgt = int'(ins[16]);
    return tgt;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL in_ready_timeout: got %b required 1", in_ready);
    end
  endtask

  task automatic load(input logic sel, input logic [31:0] data);
    wait_ready();
    ld_en = 1'b1; ld_sel = sel; ld_data = data;
    @(posedge clk); #1;
    ld_en = 1'b0;
    if (sel) m_b = data; else m_a = data;
  endtask

  task automatic issue(input logic [31:0] ins, input bit ld_during);
    exp_t        e;
    logic [34:0] fr;
    int          tgt;
    int unsigned t0;
    wait_ready();
    in_valid = 1'b1; in_instr = ins;
    t0 = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    m_trap = 1'b0;
    if (legal_ref(ins)) begin
      fr = alu_ref(ins, m_a, m_b);
      e.res = fr[31:0]; e.flags = fr[34:32]; e.err = 1'b0; e.due = t0 + 2;
      tgt = wb_target(ins);
      if (TRAP_EN && fr[32]) begin tgt = -1; m_trap = 1'b1; end
      if (tgt == 0) m_a = fr[31:0];
      else if (tgt == 1) m_b = fr[31:0];
    end else begin
      e.res = '0; e.flags = '0; e.err = 1'b1; e.due = t0 + 1;
    end
    e.ra = m_a; e.rb = m_b; e.trap = m_trap;
    sb.push_back(e);
    if (ld_during) begin
      ld_en = 1'b1; ld_sel = 1'($urandom); ld_data = $urandom;
      @(posedge clk); #1;
      ld_en = 1'b0;
    end
  endtask

  task automatic reset_check(input string tag);
    @(negedge clk);
    check({tag, "_reg_a"}, reg_a, 32'h0);
    check({tag, "_reg_b"}, reg_b, 32'h0);
    check({tag, "_out_valid"}, {31'h0, out_valid}, 32'h0);
    check({tag, "_out_result"}, out_result, 32'h0);
    check({tag, "_out_flags"}, {29'h0, out_flags}, 32'h0);
    check({tag, "_out_err"}, {31'h0, out_err}, 32'h0);
    check({tag, "_trap"}, {31'h0, trap}, 32'h0);
    check({tag, "_in_ready"}, {31'h0, in_ready}, 32'h1);
  endtask

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'($urandom_range(0, 15));
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins = $urandom;
    if ($urandom_range(0, 9) == 0) return ins;
    if ($urandom_range(0, 1) == 1) begin
      ins[31:26] = 6'h00;
      ins[5:0]   = FUNCTS[$urandom_range(0, 15)];
    end else begin
      ins[31:26] = OPS[$urandom_range(0, 10)];
    end
    ins[25:21] = 5'($urandom_range(0, 1));
    ins[20:16] = 5'($urandom_range(0, 1));
    ins[15:11] = 5'($urandom_range(0, 1));
    if ($urandom_range(0, 7) == 0) ins[15:11] = 5'($urandom_range(0, 31));
    return ins;
  endfunction

  // out_ready driver
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        1:       out_ready = 1'b0;
        2:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Response monitor: pops the scoreboard on the first cycle of each response,
  // then checks the payload stays put until the handshake.
  initial begin
    exp_t        e;
    bit          in_resp = 1'b0;
    logic [31:0] h_res;
    logic [2:0]  h_flags;
    logic        h_err;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        in_resp = 1'b0;
      end else if (out_valid === 1'b1) begin
        if (!in_resp) begin
          if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_resp: got out_valid=1 required 0 (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            check("latency", cyc, e.due);
            check("out_result", out_result, e.res);
            check("out_flags", {29'h0, out_flags}, {29'h0, e.flags});
            check("out_err", {31'h0, out_err}, {31'h0, e.err});
            check("reg_a", reg_a, e.ra);
            check("reg_b", reg_b, e.rb);
            check("trap", {31'h0, trap}, {31'h0, e.trap});
          end
          h_res = out_result; h_flags = out_flags; h_err = out_err;
          in_resp = 1'b1;
        end else begin
          check("hold_result", out_result, h_res);
          check("hold_flags", {29'h0, out_flags}, {29'h0, h_flags});
          check("hold_err", {31'h0, out_err}, {31'h0, h_err});
          check("resp_in_ready", {31'h0, in_ready}, 32'h0);
        end
        check("resp_alu_instr", alu_instruction, 32'h0);
        if (out_ready === 1'b1) in_resp = 1'b0;
      end else if (in_ready === 1'b1) begin
        check("idle_alu_instr", alu_instruction, 32'h0);
        check("idle_alu_regA", alu_regA, 32'h0);
        check("idle_alu_regB", alu_regB, 32'h0);
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_instr = '0;
    ld_en = 1'b0; ld_sel = 1'b0; ld_data = '0;
    m_a = '0; m_b = '0; m_trap = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    reset_check("reset");

    // add rd=regA: 5 + 7
    load(1'b0, 32'd5); load(1'b1, 32'd7);
    issue(32'h0001_0020, 1'b0);
    wait_ready();
    check("add_reg_a", reg_a, 32'd12);

    // signed overflow into regB
    load(1'b0, 32'h7FFF_FFFF); load(1'b1, 32'd1);
    issue(32'h0001_0820, 1'b0);
    wait_ready();
    check("ovf_reg_b", reg_b, TRAP_EN ? 32'd1 : 32'h8000_0000);

    // illegal register field rs=2
    issue(32'h0041_0020, 1'b0);

    // beq with equal operands
    load(1'b0, 32'd3); load(1'b1, 32'd3);
    issue(32'h1001_0004, 1'b0);

    // ld_en wins over in_valid in IDLE
    wait_ready();
    ld_en = 1'b1; ld_sel = 1'b0; ld_data = 32'h1234; in_valid = 1'b1; in_instr = 32'h0001_0020;
    #1 check("ld_prio_in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1;
    ld_en = 1'b0; in_valid = 1'b0; m_a = 32'h1234;
    check("ld_prio_reg_a", reg_a, 32'h1234);

    // stall in RESP with a pending offer, then release
    rmode = 1;
    @(posedge clk); #1;
    issue(32'h0001_0021, 1'b0);
    in_valid = 1'b1; in_instr = 32'h0001_0022;
    repeat (12) @(posedge clk);
    #1 rmode = 2;
    n = 0;
    do begin @(negedge clk); n++; end while (!(out_valid && out_ready) && n < 20);
    check("stall_release", {31'h0, out_valid & out_ready}, 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("stall_idle_in_ready", {31'h0, in_ready}, 32'h1);
    check("stall_idle_out_valid", {31'h0, out_valid}, 32'h0);
    rmode = 0;

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) load(1'($urandom), rand_data());
      else issue(rand_instr(), $urandom_range(0, 4) == 0);
    end

    // reset while executing addi rt=regA aborts the instruction
    load(1'b0, 32'd9);
    wait_ready();
    in_valid = 1'b1; in_instr = 32'h2000_0005;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_a = '0; m_b = '0; m_trap = 1'b0;
    reset_check("abort");

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) load(1'($urandom), rand_data());
      else issue(rand_instr(), 1'b0);
    end

    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_pending", sb.size(), 32'h0);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 in_valid  input  1  instruction offered.
REQ-004 in_ready  output  1  controller can accept an instruction this cycle.
REQ-005 in_instr  input  32  MIPS-encoded instruction.
REQ-006 ld_en  input  1  register-file load request (bench/host preload).
REQ-007 ld_sel  input  1  load target: 0 = regA, 1 = regB.
REQ-008 ld_data  input  32  load value.
REQ-009 alu_instruction, alu_regA, alu_regB  output  32 each  drive the combinational ALU.
REQ-010 alu_result  input  32; alu_flags  input  3  ALU outputs ({zero, negative, overflow}).
REQ-011 out_valid  output  1; out_ready  input  1  response handshake.
REQ-012 out_result  output  32; out_flags  output  3; out_err  output  1  response payload.
REQ-013 reg_a, reg_b  output  32 each  current register-file contents.
REQ-014 trap  output  1  overflow trap indication (Configuration only).

Function
REQ-015 State machine SHALL have states IDLE, EXEC, RESP; encoding implementer's choice.
REQ-016 in_ready SHALL be 1 only in IDLE with ld_en=0; ld_en in IDLE has priority over in_valid.
REQ-017 ld_en in IDLE SHALL write ld_data to register ld_sel at that edge; ld_en outside IDLE SHALL be ignored.
REQ-018 On in_valid&in_ready: latch in_instr into instr_q; run legality check on in_instr.
REQ-019 Legal opcodes: R-type (op 000000) funct in {100000,100001,100010,100011,100100,100111,100101,100110,101010,101011,000000,000100,000010,000110,000011,000111}; op in {001000,001001,001100,001101,001110,000100,000101,001010,001011,100011,101011}.
REQ-020 Legal registers: rs [25:21] and rt [20:16] in {0,1}; for R-type, rd [15:11] also in {0,1}.
REQ-021 Illegal instruction: go directly IDLE->RESP, out_err=1, out_result=0, out_flags=0, no register write, ALU ports SHALL stay at idle values.
REQ-022 Legal instruction: IDLE->EXEC.
REQ-023 In EXEC (exactly one cycle), alu_instruction=instr_q, alu_regA=reg_a, alu_regB=reg_b; outside EXEC all three SHALL be 32'h0.
REQ-024 At the EXEC->RESP edge, capture alu_result/alu_flags into out_result/out_flags; out_err=0.
REQ-025 Writeback at the same edge: R-type writes rd[0] register; op 001000,001001,001100,001101,001110,001010,001011 write rt[0] register; beq, bne, lw, sw SHALL NOT write.
REQ-026 RESP: out_valid=1, payload stable until out_valid&out_ready; then RESP->IDLE.
REQ-027 Latency: accept at edge T, out_valid high from edge T+2 (legal) or T+1 (illegal); max throughput one instruction per 3 cycles with out_ready held high.
REQ-028 out_ready low SHALL stall indefinitely in RESP; in_ready SHALL stay 0 until return to IDLE.
REQ-029 Writeback target equal to a source register SHALL use pre-write value for that ALU operation (write occurs after capture).

Reset
REQ-030 rst SHALL force IDLE, reg_a=reg_b=0, out_valid=0, out_result=0, out_flags=0, out_err=0, trap=0, instr_q=0.
REQ-031 rst asserted in EXEC or RESP SHALL abort: no writeback, no response; rst has priority over ld_en and in_valid.

Configuration
REQ-032 Macro ALU_SEQ_OVF_TRAP_EN: when defined, a legal instruction whose captured alu_flags[0]=1 SHALL suppress writeback and set trap=1, held until next accepted instruction or rst.
REQ-033 Without ALU_SEQ_OVF_TRAP_EN, trap SHALL be tied 0 and overflow results SHALL write back normally.

Verification
REQ-034 Load regA=5, regB=7; issue add rd=0 (0x00010020) -> out_valid at T+2, out_result=12, flags=000, reg_a=12.
REQ-035 regA=0x7FFFFFFF, regB=1; add rd=1 -> flags[0]=1; without macro reg_b=0x80000000; with macro reg_b=1, trap=1.
REQ-036 Issue instruction with rs=00010 -> out_valid at T+1, out_err=1, registers unchanged, alu_instruction stays 0.
REQ-037 beq rs=0, rt=1 with regA=regB=3 -> out_flags[2]=1, reg_a/reg_b unchanged.
REQ-038 Hold out_ready=0 for 10 cycles in RESP with in_valid=1 -> in_ready=0, payload stable throughout; release -> IDLE next cycle.
REQ-039 Assert rst during EXEC of addi writing rt=0 -> reg_a=0, out_valid=0, state IDLE next cycle.
